// File: rtl/timed_request_queue.sv
// Timed request queue: buffers trace requests in order and releases each head entry
// once the simulation clock reaches its timestamp, with optional idle fast-forward.
module timed_request_queue #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int TIME_W        = 64,
  parameter int DEPTH         = 16,
  parameter int SKIP_IDLE     = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [TIME_W-1:0]        in_time,
  input  logic [1:0]               in_op,
  input  logic [ADDRESS_WIDTH-1:0] in_addr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [1:0]               out_op,
  output logic [ADDRESS_WIDTH-1:0] out_addr,
  output logic [TIME_W-1:0]        out_time,
  output logic [TIME_W-1:0]        clock_count,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     full,
  output logic                     empty,
  output logic                     illegal_op,
  output logic                     order_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [1:0] OP_ILLEGAL = 2'd3;

  logic [TIME_W-1:0]        time_mem_q [DEPTH];
  logic [1:0]               op_mem_q   [DEPTH];
  logic [ADDRESS_WIDTH-1:0] addr_mem_q [DEPTH];

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [TIME_W-1:0] clock_q, clock_d;
  logic [TIME_W-1:0] last_time_q, last_time_d;
  logic              illegal_q, illegal_d;
  logic              order_err_q, order_err_d;

  logic              accept;
  logic              push;
  logic              pop;
  logic              skip_load;
  logic [TIME_W:0]   clock_plus1;
  logic [TIME_W-1:0] head_time;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign in_ready  = ~full;
  assign head_time = time_mem_q[head_q];

  // Release is purely from registered state: a new entry can never bypass to the output.
  assign out_valid = ~empty & (head_time <= clock_q);
  assign out_op    = empty ? 2'd0 : op_mem_q[head_q];
  assign out_addr  = empty ? '0 : addr_mem_q[head_q];
  assign out_time  = empty ? '0 : head_time;

  assign accept = in_valid & in_ready;
  assign push   = accept & (in_op != OP_ILLEGAL);
  assign pop    = out_valid & out_ready;

  // Extra bit keeps clock+1 from wrapping when the counter is saturated.
  assign clock_plus1 = {1'b0, clock_q} + 1'b1;
  assign skip_load   = (SKIP_IDLE != 0) & push & empty & ~pop &
                       ({1'b0, in_time} > clock_plus1);

  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    clock_d     = clock_q;
    last_time_d = last_time_q;
    illegal_d   = accept & (in_op == OP_ILLEGAL);
    order_err_d = push & (in_time < last_time_q);

    if (push) begin
      tail_d      = tail_q + 1'b1;
      last_time_d = in_time;
    end
    if (pop) begin
      head_d = head_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (skip_load) begin
      clock_d = in_time;
    end else if (!(&clock_q)) begin
      clock_d = clock_plus1[TIME_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      clock_q     <= '0;
      last_time_q <= '0;
      illegal_q   <= 1'b0;
      order_err_q <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      clock_q     <= clock_d;
      last_time_q <= last_time_d;
      illegal_q   <= illegal_d;
      order_err_q <= order_err_d;
    end
  end

  // Storage needs no reset; occupancy alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      time_mem_q[tail_q] <= in_time;
      op_mem_q[tail_q]   <= in_op;
      addr_mem_q[tail_q] <= in_addr;
    end
  end

  assign clock_count = clock_q;
  assign occupancy   = count_q;
  assign illegal_op  = illegal_q;
  assign order_err   = order_err_q;

endmodule

// File: tb/tb_timed_request_queue.sv
// Directed bench for timed_request_queue: a vector table for the basic timeline, plus
// sequences for fill/wrap, idle skip, order release and mid-operation reset.
module tb_timed_request_queue;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [63:0] in_time;
  logic [1:0]  in_op;
  logic [31:0] in_addr;
  logic        out_ready;

  logic        o0_in_ready, o0_out_valid, o0_full, o0_empty, o0_ill, o0_oerr;
  logic [1:0]  o0_out_op;
  logic [31:0] o0_out_addr;
  logic [63:0] o0_out_time, o0_cc;
  logic [4:0]  o0_occ;

  logic        o1_in_ready, o1_out_valid, o1_full, o1_empty, o1_ill, o1_oerr;
  logic [1:0]  o1_out_op;
  logic [31:0] o1_out_addr;
  logic [63:0] o1_out_time, o1_cc;
  logic [4:0]  o1_occ;

  int checks = 0;
  int errors = 0;

  timed_request_queue #(.ADDRESS_WIDTH(32), .TIME_W(64), .DEPTH(16), .SKIP_IDLE(0)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o0_in_ready),
    .in_time(in_time), .in_op(in_op), .in_addr(in_addr),
    .out_valid(o0_out_valid), .out_ready(out_ready), .out_op(o0_out_op),
    .out_addr(o0_out_addr), .out_time(o0_out_time), .clock_count(o0_cc),
    .occupancy(o0_occ), .full(o0_full), .empty(o0_empty),
    .illegal_op(o0_ill), .order_err(o0_oerr)
  );

  timed_request_queue #(.ADDRESS_WIDTH(32), .TIME_W(64), .DEPTH(16), .SKIP_IDLE(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o1_in_ready),
    .in_time(in_time), .in_op(in_op), .in_addr(in_addr),
    .out_valid(o1_out_valid), .out_ready(out_ready), .out_op(o1_out_op),
    .out_addr(o1_out_addr), .out_time(o1_out_time), .clock_count(o1_cc),
    .occupancy(o1_occ), .full(o1_full), .empty(o1_empty),
    .illegal_op(o1_ill), .order_err(o1_oerr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        rst;
    logic        vld;
    logic [63:0] tm;
    logic [1:0]  op;
    logic [31:0] addr;
    logic        ordy;
    logic        e_ready;
    logic        e_valid;
    logic [31:0] e_addr;
    logic [4:0]  e_occ;
    logic [63:0] e_cc;
    logic        e_ill;
    logic        e_oerr;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(logic r, logic v, logic [63:0] t, logic [1:0] o,
                              logic [31:0] a, logic rd, logic erdy, logic evld,
                              logic [31:0] eaddr, logic [4:0] eocc, logic [63:0] ecc,
                              logic eill, logic eoerr);
    vec_t x;
    x.rst = r; x.vld = v; x.tm = t; x.op = o; x.addr = a; x.ordy = rd;
    x.e_ready = erdy; x.e_valid = evld; x.e_addr = eaddr; x.e_occ = eocc;
    x.e_cc = ecc; x.e_ill = eill; x.e_oerr = eoerr;
    return x;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Inputs are applied at the falling edge, the rising edge acts, results sampled at the next falling edge.
  task automatic drive(input logic r, input logic v, input logic [63:0] t, input logic [1:0] o,
                       input logic [31:0] a, input logic rd);
    rst = r; in_valid = v; in_time = t; in_op = o; in_addr = a; out_ready = rd;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; in_time = '0; in_op = '0; in_addr = '0; out_ready = 1'b0;

    //                 rst vld time op addr    rdy | ready valid addr   occ cc  ill oerr
    vecs[0]  = mk(1, 0, 0,  0, 32'h0,    1,  1, 0, 32'h0,    0, 0,  0, 0);
    vecs[1]  = mk(0, 1, 5,  0, 32'h1000, 1,  1, 0, 32'h1000, 1, 1,  0, 0);
    vecs[2]  = mk(0, 0, 0,  0, 32'h0,    1,  1, 0, 32'h1000, 1, 2,  0, 0);
    vecs[3]  = mk(0, 0, 0,  0, 32'h0,    1,  1, 0, 32'h1000, 1, 3,  0, 0);
    vecs[4]  = mk(0, 0, 0,  0, 32'h0,    1,  1, 0, 32'h1000, 1, 4,  0, 0);
    vecs[5]  = mk(0, 0, 0,  0, 32'h0,    1,  1, 1, 32'h1000, 1, 5,  0, 0);
    vecs[6]  = mk(0, 0, 0,  0, 32'h0,    1,  1, 0, 32'h0,    0, 6,  0, 0);
    vecs[7]  = mk(0, 1, 0,  3, 32'hDEAD, 1,  1, 0, 32'h0,    0, 7,  1, 0);
    vecs[8]  = mk(0, 0, 0,  0, 32'h0,    1,  1, 0, 32'h0,    0, 8,  0, 0);
    vecs[9]  = mk(0, 1, 50, 1, 32'hA,    1,  1, 0, 32'hA,    1, 9,  0, 0);
    vecs[10] = mk(0, 1, 20, 2, 32'hB,    1,  1, 0, 32'hA,    2, 10, 0, 1);
    vecs[11] = mk(0, 0, 0,  0, 32'h0,    1,  1, 0, 32'hA,    2, 11, 0, 0);

    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].rst, vecs[i].vld, vecs[i].tm, vecs[i].op, vecs[i].addr, vecs[i].ordy);
      chk($sformatf("v%0d in_ready", i),    64'(o0_in_ready),  64'(vecs[i].e_ready));
      chk($sformatf("v%0d out_valid", i),   64'(o0_out_valid), 64'(vecs[i].e_valid));
      chk($sformatf("v%0d out_addr", i),    64'(o0_out_addr),  64'(vecs[i].e_addr));
      chk($sformatf("v%0d occupancy", i),   64'(o0_occ),       64'(vecs[i].e_occ));
      chk($sformatf("v%0d clock_count", i), o0_cc,             vecs[i].e_cc);
      chk($sformatf("v%0d illegal_op", i),  64'(o0_ill),       64'(vecs[i].e_ill));
      chk($sformatf("v%0d order_err", i),   64'(o0_oerr),      64'(vecs[i].e_oerr));
    end

    // Out-of-order entry waits behind the time=50 head.
    n = 0;
    while (!o0_out_valid && n < 100) begin
      drive(0, 0, 0, 0, 0, 1);
      n++;
    end
    chk("order first_valid_cc", o0_cc, 64'd50);
    chk("order head_addr", 64'(o0_out_addr), 64'hA);
    chk("order head_time", o0_out_time, 64'd50);
    chk("order head_op", 64'(o0_out_op), 64'd1);
    drive(0, 0, 0, 0, 0, 1);
    chk("order second_valid", 64'(o0_out_valid), 64'd1);
    chk("order second_addr", 64'(o0_out_addr), 64'hB);
    chk("order second_time", o0_out_time, 64'd20);
    chk("order second_op", 64'(o0_out_op), 64'd2);
    drive(0, 0, 0, 0, 0, 1);
    chk("order drained_empty", 64'(o0_empty), 64'd1);
    chk("order oerr_quiet", 64'(o0_oerr), 64'd0);

    // Fill to full from a head offset of one so the tail wraps.
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 32'h99, 0);
    chk("wrap pre_occ", 64'(o0_occ), 64'd1);
    drive(0, 0, 0, 0, 0, 1);
    chk("wrap pre_pop_occ", 64'(o0_occ), 64'd0);
    for (int i = 0; i < 16; i++) begin
      drive(0, 1, 0, 2'(i % 3), 32'h100 + i, 0);
      chk($sformatf("fill occ%0d", i), 64'(o0_occ), 64'(i + 1));
    end
    chk("full flag", 64'(o0_full), 64'd1);
    chk("full in_ready", 64'(o0_in_ready), 64'd0);
    chk("full head_addr", 64'(o0_out_addr), 64'h100);
    drive(0, 1, 0, 0, 32'hBAD, 1);
    chk("full no_push_through", 64'(o0_occ), 64'd15);
    for (int i = 1; i < 16; i++) begin
      chk($sformatf("drain valid%0d", i), 64'(o0_out_valid), 64'd1);
      chk($sformatf("drain addr%0d", i), 64'(o0_out_addr), 64'(32'h100 + i));
      chk($sformatf("drain op%0d", i), 64'(o0_out_op), 64'(i % 3));
      drive(0, 0, 0, 0, 0, 1);
    end
    chk("drain empty", 64'(o0_empty), 64'd1);
    chk("drain occ", 64'(o0_occ), 64'd0);
    drive(0, 1, 0, 0, 32'h200, 0);
    drive(0, 1, 0, 0, 32'h201, 1);
    chk("pushpop occ", 64'(o0_occ), 64'd1);
    chk("pushpop head", 64'(o0_out_addr), 64'h201);

    // Idle fast-forward on the SKIP_IDLE=1 instance; u0 keeps counting.
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    chk("skip pre_cc", o1_cc, 64'd3);
    drive(0, 1, 64'd1000, 0, 32'h2000, 0);
    chk("skip cc", o1_cc, 64'd1000);
    chk("skip valid", 64'(o1_out_valid), 64'd1);
    chk("skip out_time", o1_out_time, 64'd1000);
    chk("skip out_addr", 64'(o1_out_addr), 64'h2000);
    chk("noskip cc", o0_cc, 64'd4);
    chk("noskip valid", 64'(o0_out_valid), 64'd0);

    // Reset with entries pending flushes everything.
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 1, 0, 0, 32'h300 + i, 0);
    chk("rst pre_occ", 64'(o0_occ), 64'd5);
    chk("rst pre_valid", 64'(o0_out_valid), 64'd1);
    drive(1, 0, 0, 0, 0, 1);
    chk("rst occ", 64'(o0_occ), 64'd0);
    chk("rst valid", 64'(o0_out_valid), 64'd0);
    chk("rst cc", o0_cc, 64'd0);
    chk("rst out_addr", 64'(o0_out_addr), 64'd0);
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0, 0, 1);
      chk($sformatf("rst quiet%0d", i), 64'(o0_out_valid), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/timed_request_queue.md
Name: timed_request_queue

Overview:
- Parametrised successor to the trace parser's output stage.
- Buffers parsed trace requests (CPU time, opcode, address) from the upstream trace reader in a DEPTH-entry circular queue, keeping them in order.
- Owns the simulation clock counter and releases each head request to the DRAM controller front end once clock_count reaches that request's time. Uses valid/ready on both sides.
- Adds what the single-entry parser lacks: backpressure, multi-entry buffering, illegal-opcode filtering, trace-order checking, and optional idle fast-forward of time.

Parameters:
- ADDRESS_WIDTH, 32, request address width
- TIME_W, 64, width of clock_count and request timestamps
- DEPTH, 16, queue entries; power of 2, minimum 2
- SKIP_IDLE, 1, 1 = fast-forward clock_count to the next request time when idle; 0 = count every cycle only

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream request valid
- in_ready  out  1  queue can accept; equals ~full
- in_time  in  TIME_W  request CPU time
- in_op  in  2  opcode: 0 read, 1 write, 2 ifetch, 3 illegal
- in_addr  in  ADDRESS_WIDTH  request address
- out_valid  out  1  head request is due
- out_ready  in  1  downstream accepts
- out_op  out  2  head opcode
- out_addr  out  ADDRESS_WIDTH  head address
- out_time  out  TIME_W  head timestamp
- clock_count  out  TIME_W  current simulation time
- occupancy  out  $clog2(DEPTH)+1  entries held
- full  out  1  occupancy == DEPTH
- empty  out  1  occupancy == 0
- illegal_op  out  1  one-cycle pulse: illegal opcode dropped
- order_err  out  1  one-cycle pulse: timestamp went backwards

Behaviour:
- Reset (rst=1 at an edge):
  - Clears pointers, occupancy, clock_count, last_time, illegal_op and order_err.
  - Outputs after reset: in_ready=1, out_valid=0, out_op/out_addr/out_time=0, empty=1, full=0.
  - Reset mid-operation flushes all entries with no output.
- Push:
  - Occurs when in_valid & in_ready and in_op != 3. The entry is written at the tail, tail advances, and wrap is modulo DEPTH.
  - in_ready is 0 when full, with no push-through, even if a pop happens in the same cycle.
- Illegal opcode:
  - in_op == 3 with in_valid & in_ready is consumed (handshake completes) but not stored.
  - illegal_op pulses high in the next cycle.
  - last_time is not updated.
- Order check:
  - A legal push with in_time < last_time pulses order_err in the next cycle.
  - The entry is still enqueued, and last_time is updated to in_time.
  - Equal times are legal.
- Release:
  - out_valid = ~empty & (head.time <= clock_count), combinational from registered state.
  - out_op, out_addr and out_time always show the head entry when nonempty, and 0 when empty.
  - Pop occurs on out_valid & out_ready. Head fields stay stable until popped.
  - Strict FIFO order: a later entry with an earlier time waits behind the head.
- Latency: a push at edge t is visible at the head, and can be valid, no earlier than the cycle after edge t. There is no empty-queue bypass.
- Simultaneous push and pop (not full): occupancy is unchanged and both pointers advance.
- clock_count:
  - Increments by 1 every cycle after reset and saturates at 2^TIME_W-1.
  - With SKIP_IDLE=1, a legal push into an empty queue (no pop that cycle) where in_time > clock_count+1 loads clock_count <= in_time instead of incrementing.
  - With SKIP_IDLE=0, there is no skip.
- Timestamp comparisons are unsigned over the full TIME_W bits.

Test Plan:
- Reset, then push (time=5, op=0, addr=0x0000_1000) at cycle 1 with SKIP_IDLE=0 and out_ready=1 -> out_valid first high when clock_count=5 with op=0, addr=0x1000; pops; empty=1 the next cycle.
- SKIP_IDLE=1, push time=1000 into the empty queue at clock_count=3 -> clock_count=1000 the next cycle; out_valid=1 with out_time=1000.
- Push 16 entries with time=0 while out_ready=0 -> full=1, in_ready=0, occupancy=16. Then out_ready=1 -> 16 pops in push order, correct across pointer wrap, empty=1 at the end.
- Push op=3 addr=0xDEAD -> handshake completes, illegal_op=1 for exactly one cycle, occupancy unchanged, nothing emitted.
- Push time=50 then time=20 -> order_err pulses once. The time=20 entry issues only after time=50 is popped, at clock_count>=50.
- Assert rst with 5 entries queued while out_valid=1 -> the next cycle has occupancy=0, out_valid=0 and clock_count=0; nothing is emitted afterwards.
